// File: rtl/analog_pkg.sv
// Shared definitions for the analog front-end power sequencer: FSM encodings and DAC bus layout.
package analog_pkg;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_WAKE_ADC = 3'd1,
      ST_WAKE_DAC = 3'd2,
      ST_ACTIVE   = 3'd3,
      ST_MUTE     = 3'd4
   } pwr_state_t;

   localparam int DAC_W     = 14;
   localparam int DAC_LANES = 4;
   localparam int DAC_BUS_W = DAC_W * DAC_LANES;

   // Two's complement midscale; the bridge converts to offset binary downstream.
   localparam logic signed [DAC_W-1:0] DAC_MIDSCALE = '0;

   function automatic logic [DAC_BUS_W-1:0] midscale_bus();
      return {DAC_LANES{DAC_MIDSCALE}};
   endfunction

endpackage

// File: rtl/analog_power_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/analog_power_sequencer.sv
// Power-up/down sequencer for the ADC pair and dual DACs feeding the analog bridge user ports.
module analog_power_sequencer
   import analog_pkg::*;
#(
   parameter int ADC_WAKE_CYC = 256,
   parameter int DAC_WAKE_CYC = 64,
   parameter int MUTE_CYC     = 16,
   parameter int CNT_W        = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 ready,
   output logic [2:0]           state,
   input  logic [DAC_BUS_W-1:0] dac_in,
   output logic [DAC_BUS_W-1:0] dac_out,
   output logic                 dac1_sleep,
   output logic                 dac2_sleep,
   output logic                 adc_pdwnA,
   output logic                 adc_pdwnB,
   input  logic                 adc_otrA,
   input  logic                 adc_otrB,
   input  logic                 otr_clear,
   output logic [CNT_W-1:0]     otr_cntA,
   output logic [CNT_W-1:0]     otr_cntB
);

   localparam logic [CNT_W-1:0] ADC_LAST  = CNT_W'(ADC_WAKE_CYC - 1);
   localparam logic [CNT_W-1:0] DAC_LAST  = CNT_W'(DAC_WAKE_CYC - 1);
   localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_CYC - 1);

   pwr_state_t       state_q;
   pwr_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:      if (enable) state_d = ST_WAKE_ADC;
         ST_WAKE_ADC: begin
            if (!enable)                state_d = ST_OFF;
            else if (cnt_q == ADC_LAST) state_d = ST_WAKE_DAC;
         end
         ST_WAKE_DAC: begin
            if (!enable)                state_d = ST_MUTE;
            else if (cnt_q == DAC_LAST) state_d = ST_ACTIVE;
         end
         ST_ACTIVE:   if (!enable) state_d = ST_MUTE;
         ST_MUTE:     if (cnt_q == MUTE_LAST) state_d = ST_OFF;
         default:     state_d = ST_OFF;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as state_q.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         ready      <= 1'b0;
         dac_out    <= '0;
         dac1_sleep <= 1'b1;
         dac2_sleep <= 1'b1;
         adc_pdwnA  <= 1'b1;
         adc_pdwnB  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= ((state_d != state_q) || (state_q == ST_OFF)) ? '0 : cnt_q + CNT_W'(1);
         ready      <= (state_d == ST_ACTIVE);
         dac_out    <= (state_d == ST_ACTIVE) ? dac_in : midscale_bus();
         dac1_sleep <= (state_d == ST_OFF) || (state_d == ST_WAKE_ADC);
         dac2_sleep <= (state_d == ST_OFF) || (state_d == ST_WAKE_ADC);
         adc_pdwnA  <= (state_d == ST_OFF);
         adc_pdwnB  <= (state_d == ST_OFF);
      end
   end

   assign state = state_q;

   sat_counter #(.CNT_W(CNT_W)) u_otr_a (
      .clock (clock),
      .reset (reset),
      .inc   ((state_q == ST_ACTIVE) && adc_otrA),
      .clr   (otr_clear),
      .count (otr_cntA)
   );

   sat_counter #(.CNT_W(CNT_W)) u_otr_b (
      .clock (clock),
      .reset (reset),
      .inc   ((state_q == ST_ACTIVE) && adc_otrB),
      .clr   (otr_clear),
      .count (otr_cntB)
   );

endmodule

// File: tb/tb_analog_power_sequencer.sv
// Bench for analog_power_sequencer: directed sequences with literal expectations plus a randomized run.
module tb_analog_power_sequencer;

   localparam int ADC_WAKE_CYC = 4;
   localparam int DAC_WAKE_CYC = 3;
   localparam int MUTE_CYC     = 2;
   localparam int CNT_W        = 3;
   localparam int CMAX         = (1 << CNT_W) - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              ready;
   logic [2:0]        state;
   logic [55:0]       dac_in = '0;
   logic [55:0]       dac_out;
   logic              dac1_sleep, dac2_sleep, adc_pdwnA, adc_pdwnB;
   logic              adc_otrA = 1'b0, adc_otrB = 1'b0, otr_clear = 1'b0;
   logic [CNT_W-1:0]  otr_cntA, otr_cntB;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   analog_power_sequencer #(
      .ADC_WAKE_CYC(ADC_WAKE_CYC), .DAC_WAKE_CYC(DAC_WAKE_CYC),
      .MUTE_CYC(MUTE_CYC), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .ready(ready), .state(state),
      .dac_in(dac_in), .dac_out(dac_out), .dac1_sleep(dac1_sleep), .dac2_sleep(dac2_sleep),
      .adc_pdwnA(adc_pdwnA), .adc_pdwnB(adc_pdwnB), .adc_otrA(adc_otrA), .adc_otrB(adc_otrB),
      .otr_clear(otr_clear), .otr_cntA(otr_cntA), .otr_cntB(otr_cntB)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase number, cycles spent in that phase, held sample and counts.
   int          m_st = 0;
   int          m_age = 0;
   int          m_nxt;
   logic [55:0] m_dac = '0;
   int          m_cA = 0, m_cB = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_st = 0; m_age = 0; m_dac = '0; m_cA = 0; m_cB = 0;
      end else begin
         m_nxt = m_st;
         case (m_st)
            0: if (enable) m_nxt = 1;
            1: if (!enable) m_nxt = 0; else if (m_age == ADC_WAKE_CYC - 1) m_nxt = 2;
            2: if (!enable) m_nxt = 4; else if (m_age == DAC_WAKE_CYC - 1) m_nxt = 3;
            3: if (!enable) m_nxt = 4;
            default: if (m_age == MUTE_CYC - 1) m_nxt = 0;
         endcase
         if (otr_clear) m_cA = 0;
         else if (m_st == 3 && adc_otrA && m_cA < CMAX) m_cA = m_cA + 1;
         if (otr_clear) m_cB = 0;
         else if (m_st == 3 && adc_otrB && m_cB < CMAX) m_cB = m_cB + 1;
         m_dac = (m_nxt == 3) ? dac_in : 56'h0;
         m_age = (m_nxt == m_st) ? m_age + 1 : 0;
         m_st  = m_nxt;
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         chk("state",      64'(state),      64'(m_st));
         chk("ready",      64'(ready),      64'(m_st == 3));
         chk("adc_pdwnA",  64'(adc_pdwnA),  64'(m_st == 0));
         chk("adc_pdwnB",  64'(adc_pdwnB),  64'(m_st == 0));
         chk("dac1_sleep", 64'(dac1_sleep), 64'(m_st <= 1));
         chk("dac2_sleep", 64'(dac2_sleep), 64'(m_st <= 1));
         chk("dac_out",    64'(dac_out),    64'(m_dac));
         chk("otr_cntA",   64'(otr_cntA),   64'(m_cA));
         chk("otr_cntB",   64'(otr_cntB),   64'(m_cB));
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 64'(state), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd0);
      chk({tag, "_dac_out"}, 64'(dac_out), 64'd0);
      chk({tag, "_sleep"}, 64'({dac1_sleep, dac2_sleep}), 64'd3);
      chk({tag, "_pdwn"}, 64'({adc_pdwnA, adc_pdwnB}), 64'd3);
      chk({tag, "_otr"}, 64'({otr_cntA, otr_cntB}), 64'd0);
   endtask

   initial begin
      step(2);
      chk_reset_vals("reset");
      reset = 1'b0;
      check_en = 1'b1;

      // Power-up timeline with dac_in held at 1.
      dac_in = 56'h1;
      enable = 1'b1;
      step(1);
      chk("up_state1", 64'(state), 64'd1);
      chk("up_pdwn_low", 64'(adc_pdwnA), 64'd0);
      chk("up_sleep_hi", 64'(dac1_sleep), 64'd1);
      step(3);
      chk("up_still_wake_adc", 64'(state), 64'd1);
      step(1);
      chk("up_state2", 64'(state), 64'd2);
      chk("up_sleep_low", 64'(dac2_sleep), 64'd0);
      step(2);
      chk("up_not_ready", 64'(ready), 64'd0);
      step(1);
      chk("up_ready", 64'(ready), 64'd1);
      chk("up_state3", 64'(state), 64'd3);
      chk("up_dac_first", 64'(dac_out), 64'h1);

      // Over-range counting: 5 cycles active, then shutdown and 3 cycles in OFF.
      adc_otrA = 1'b1;
      step(5);
      adc_otrA = 1'b0;
      step(1);
      chk("otr_five", 64'(otr_cntA), 64'd5);
      enable = 1'b0;
      step(1);
      chk("mute_state", 64'(state), 64'd4);
      chk("mute_dac_zero", 64'(dac_out), 64'd0);
      chk("mute_sleep_low", 64'(dac1_sleep), 64'd0);
      step(1);
      chk("mute_hold", 64'(state), 64'd4);
      step(1);
      chk("off_state", 64'(state), 64'd0);
      chk("off_pdwn", 64'(adc_pdwnB), 64'd1);
      chk("off_sleep", 64'(dac2_sleep), 64'd1);
      adc_otrA = 1'b1;
      step(3);
      adc_otrA = 1'b0;
      chk("otr_hold_off", 64'(otr_cntA), 64'd5);

      // Wake abort during WAKE_ADC.
      enable = 1'b1;
      step(1);
      chk("abort_wake", 64'(state), 64'd1);
      enable = 1'b0;
      step(1);
      chk("abort_off", 64'(state), 64'd0);
      chk("abort_pdwn", 64'(adc_pdwnA), 64'd1);
      chk("abort_sleep", 64'(dac1_sleep), 64'd1);

      // Saturation and clear priority.
      enable = 1'b1;
      step(8);
      chk("reup_ready", 64'(ready), 64'd1);
      adc_otrA = 1'b1;
      step(10);
      chk("otr_sat", 64'(otr_cntA), 64'd7);
      otr_clear = 1'b1;
      step(1);
      chk("otr_clear_wins", 64'(otr_cntA), 64'd0);
      otr_clear = 1'b0;
      adc_otrA = 1'b0;

      // Re-enable mid-MUTE does not abort the shutdown.
      enable = 1'b0;
      step(1);
      chk("remute_state", 64'(state), 64'd4);
      enable = 1'b1;
      step(1);
      chk("remute_hold", 64'(state), 64'd4);
      step(1);
      chk("remute_off", 64'(state), 64'd0);
      step(1);
      chk("remute_wake", 64'(state), 64'd1);

      // Reset while active with traffic.
      step(7);
      chk("pre_reset_ready", 64'(ready), 64'd1);
      adc_otrB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dac_in = 56'({$urandom, $urandom});
         step(1);
      end
      reset = 1'b1;
      step(1);
      chk_reset_vals("active_reset");
      reset = 1'b0;
      adc_otrB = 1'b0;

      // Randomized run against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(39) == 0) enable = ~enable;
         dac_in    = 56'({$urandom, $urandom});
         adc_otrA  = ($urandom_range(2) == 0);
         adc_otrB  = ($urandom_range(1) == 0);
         otr_clear = ($urandom_range(59) == 0);
         reset     = ($urandom_range(799) == 0);
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
